// File: rtl/div_seq_datapath_ctrl.sv
// Sequential restoring unsigned divider: dividend and divisor are loaded over a shared bus,
// then one quotient bit is resolved per clock. The controller offers a done/busy handshake.
module div_seq_datapath_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  // R stays below B, so a negative trial difference always sets the top bit of diff.
  always_comb begin
    trial  = {r_q, q_q[WIDTH-1]};
    diff   = trial - {1'b0, b_q};
    fits   = ~diff[WIDTH];
    r_step = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    q_step = {q_q[WIDTH-2:0], fits};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    q_d         = q_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = done_q;
    busy_d      = busy_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD_A;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      LOAD_A: begin
        a_d     = data_in;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        b_d     = data_in;
        r_d     = '0;
        q_d     = a_q;
        count_d = CW'(WIDTH);
        if (data_in == '0) begin
          quotient_d  = '1;
          remainder_d = a_q;
          dbz_d       = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        r_d     = r_step;
        q_d     = q_step;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          quotient_d  = q_step;
          remainder_d = r_step;
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      q_q         <= q_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_datapath_ctrl.sv
// Directed-vector bench for div_seq_datapath_ctrl: latency, results, handshake,
// divide-by-zero, async reset mid-operation and result hold across back-to-back operations.
module tb_div_seq_datapath_ctrl;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  int n_vec;
  int n_err;

  logic [WIDTH-1:0] held_q;
  logic [WIDTH-1:0] held_r;
  logic             held_dbz;

  div_seq_datapath_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_vec++;
    if (observed !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One full operation driven from IDLE or DONE; inputs change and outputs are sampled on negedges.
  task automatic applyStimulus(input logic [WIDTH-1:0] dividend, input logic [WIDTH-1:0] divisor,
                               input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r,
                               input logic exp_dbz, input bit poke_start);
    int cycles;
    int exp_cycles;
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'h5A5A;
    @(negedge clk);
    start   = 1'b0;
    data_in = dividend;
    checkOutput("busy_in_load_a", {31'd0, busy}, 32'd1);
    checkOutput("done_cleared", {31'd0, done}, 32'd0);
    checkOutput("hold_quotient", {16'd0, quotient}, {16'd0, held_q});
    checkOutput("hold_remainder", {16'd0, remainder}, {16'd0, held_r});
    @(negedge clk);
    data_in = divisor;
    cycles  = 0;
    while (!done && cycles < 2 * WIDTH + 8) begin
      @(negedge clk);
      cycles++;
      data_in = 16'hC3C3;
      start   = (poke_start && cycles == 5) ? 1'b1 : 1'b0;
      checkOutput("busy_done_overlap", {31'd0, busy & done}, 32'd0);
      if (!done) checkOutput("hold_dbz", {31'd0, div_by_zero}, {31'd0, held_dbz});
    end
    start      = 1'b0;
    exp_cycles = exp_dbz ? 1 : WIDTH + 1;
    checkOutput("latency", cycles, exp_cycles);
    checkOutput("quotient", {16'd0, quotient}, {16'd0, exp_q});
    checkOutput("remainder", {16'd0, remainder}, {16'd0, exp_r});
    checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_dbz});
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("done_held", {31'd0, done}, 32'd1);
    checkOutput("quotient_held", {16'd0, quotient}, {16'd0, exp_q});
    held_q   = exp_q;
    held_r   = exp_r;
    held_dbz = exp_dbz;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_quotient"}, {16'd0, quotient}, 32'd0);
    checkOutput({tag, "_remainder"}, {16'd0, remainder}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    held_q   = '0;
    held_r   = '0;
    held_dbz = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    data_in  = '0;
    #1;
    checkResetOutputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("idle");

    applyStimulus(16'd17,    16'd5,     16'd3,     16'd2,     1'b0, 1'b0);
    applyStimulus(16'd65535, 16'd1,     16'd65535, 16'd0,     1'b0, 1'b0);
    applyStimulus(16'd5,     16'd17,    16'd0,     16'd5,     1'b0, 1'b0);
    applyStimulus(16'd40000, 16'd40000, 16'd1,     16'd0,     1'b0, 1'b0);
    applyStimulus(16'd100,   16'd0,     16'hFFFF,  16'd100,   1'b1, 1'b0);
    applyStimulus(16'd1000,  16'd7,     16'd142,   16'd6,     1'b0, 1'b1);
    applyStimulus(16'd65535, 16'd65535, 16'd1,     16'd0,     1'b0, 1'b0);
    applyStimulus(16'd65535, 16'd32768, 16'd1,     16'd32767, 1'b0, 1'b0);
    applyStimulus(16'd0,     16'd3,     16'd0,     16'd0,     1'b0, 1'b0);
    applyStimulus(16'd0,     16'd0,     16'hFFFF,  16'd0,     1'b1, 1'b0);
    applyStimulus(16'd12345, 16'd123,   16'd100,   16'd45,    1'b0, 1'b1);
    applyStimulus(16'd50000, 16'd3,     16'd16666, 16'd2,     1'b0, 1'b0);
    applyStimulus(16'd32768, 16'd2,     16'd16384, 16'd0,     1'b0, 1'b0);
    applyStimulus(16'd1,     16'd65535, 16'd0,     16'd1,     1'b0, 1'b0);
    applyStimulus(16'd60000, 16'd250,   16'd240,   16'd0,     1'b0, 1'b0);
    applyStimulus(16'd65534, 16'd65535, 16'd0,     16'd65534, 1'b0, 1'b0);

    // Abort an operation part-way through CALC with an asynchronous reset.
    @(negedge clk);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'd17;
    @(negedge clk);
    data_in = 16'd5;
    repeat (8) @(negedge clk);
    checkOutput("mid_calc_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    @(negedge clk);
    rst_n    = 1'b1;
    held_q   = '0;
    held_r   = '0;
    held_dbz = 1'b0;
    @(negedge clk);
    checkResetOutputs("after_abort");
    applyStimulus(16'd17,    16'd5,     16'd3,     16'd2,     1'b0, 1'b0);
    applyStimulus(16'd1000,  16'd7,     16'd142,   16'd6,     1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
